bit_seq_transmitter: RTL and testbench
======================================

// Module: bit_seq_transmitter
// PURPOSE
//  Serial pattern source: the transmit end of the single-bit sequence link.
//  - Captures a DATA_W-bit pattern on a start request.
//  - Shifts the pattern out MSB-first, one bit per i_clk, on o_bit_seq.
//  - Repeats the frame N times, with a programmable idle gap between frames.
//  - Drives the sequence-detector receiver and test harnesses.
// PARAMETERS
//  DATA_W    8  pattern/frame width in bits (>=2)
//  REPEAT_W  4  width of the frame-count input
//  GAP_W     4  width of the inter-frame gap input (cycles)
// PORTS
//  i_clk      in   1         single clock; all logic on posedge
//  i_rst      in   1         synchronous, active-high reset
//  i_start    in   1         start request; sampled only in IDLE
//  i_data     in   DATA_W    pattern; captured when start is accepted
//  i_repeat   in   REPEAT_W  frame count; 0 is treated as 1
//  i_gap      in   GAP_W     idle cycles between frames; 0 = back-to-back
//  o_bit_seq  out  1         serial data; 0 when not shifting
//  o_bit_vld  out  1         high in every cycle o_bit_seq carries a frame bit
//  o_busy     out  1         high from the accept cycle +1 until return to IDLE
//  o_done     out  1         1-cycle pulse after the last bit of the last frame
// BEHAVIOUR
//  - All outputs are registered.
//  - Reset values: o_bit_seq=0, o_bit_vld=0, o_busy=0, o_done=0.
//  - Reset also clears the shift register, bit counter, frame counter, gap counter and state.
//  - FSM states: IDLE, SHIFT, GAP.
//  - IDLE -> SHIFT on i_start.
//      - In the same edge, latch i_data, frames=max(i_repeat,1) and i_gap.
//      - Load bit counter = DATA_W-1.
//  - Start latency: the first bit (MSB) appears on o_bit_seq with o_bit_vld=1 in
//    the cycle after i_start is sampled.
//  - SHIFT:
//      - Each bit is held exactly one cycle; MSB..LSB order.
//      - When the bit counter reaches 0, the current frame ends. Then:
//          - frames remaining >1 and gap>0 -> GAP.
//          - frames remaining >1 and gap==0 -> stay in SHIFT; reload pattern; next MSB
//            follows with no bubble.
//          - frames remaining ==1 -> IDLE, with o_done=1 for that one cycle.
//  - GAP:
//      - o_bit_seq=0 and o_bit_vld=0 for exactly gap cycles.
//      - Then SHIFT, reloading the latched pattern.
//  - Frame counter: decrements at each frame end. A full frame count of 2^REPEAT_W-1
//    must not wrap.
//  - o_busy=1 in every SHIFT/GAP cycle; 0 in IDLE.
//  - i_start while busy: ignored; i_data/i_repeat/i_gap changes do not affect the frame in flight.
//  - i_start during the o_done cycle: state is IDLE, so the start is accepted.
//    The next MSB appears the following cycle.
//  - Reset mid-frame:
//      - At the reset edge, outputs go to reset values.
//      - No o_done; the partial frame is abandoned.
//      - Reset has priority over i_start.
// CONFIGURATION
//  PARITY_EN defined:
//    - Each frame is DATA_W+1 bits: the DATA_W pattern bits, then one even-parity
//      bit (XOR of the pattern) with o_bit_vld=1.
//    - The bit counter is widened accordingly.
//    - Gap and o_done timing move one cycle later.
//  PARITY_EN undefined: frame is exactly DATA_W bits; no parity logic synthesised.
// TESTING
//  1. Reset 3 cycles; hold i_start=0.
//     -> o_bit_seq/o_bit_vld/o_busy/o_done all 0 throughout.
//  2. i_data=8'hED, i_repeat=1, i_gap=0; start at cycle T.
//     -> cycles T+1..T+8: bits 1,1,1,0,1,1,0,1 with vld=1.
//     -> o_done=1 at T+9 only; busy T+1..T+8.
//  3. i_data=8'hA5, i_repeat=2, i_gap=3.
//     -> 8 bits 10100101, then 3 cycles vld=0/bit=0, then 10100101 again.
//     -> o_done 1 cycle after the 2nd frame.
//  4. i_data=8'h0F, i_repeat=0, i_gap=0.
//     -> a single frame 00001111 (repeat 0 -> 1).
//     -> i_start pulsed again at bit 4 with i_data=8'hFF is ignored.
//  5. Start with 8'hED; assert i_rst for 1 cycle after the 4th bit.
//     -> from the reset edge on, all outputs are 0; no o_done.
//     -> a fresh start then transmits normally.
//  6. PARITY_EN, i_data=8'hED then 8'h01, i_repeat=1.
//     -> 9-bit frames ending in parity 0 then 1.
//     -> o_done at T+10.

Source files
------------

// File: rtl/bit_seq_transmitter.sv
// rtl/bit_seq_transmitter.sv - serial pattern source for the single-bit sequence link
//
// Captures a DATA_W-bit pattern on i_start and shifts it out MSB-first on
// o_bit_seq, one bit per clock. The frame repeats max(i_repeat,1) times with
// i_gap idle cycles between frames. All outputs are registered.
//
// Optional feature macro: PARITY_EN
//   defined   - each frame gets one trailing even-parity bit (DATA_W+1 bits)
//   undefined - frame is exactly DATA_W bits
//
// Ports:
//   i_clk      clock, all logic on posedge
//   i_rst      synchronous active-high reset
//   i_start    start request, sampled only in IDLE
//   i_data     pattern, captured when start is accepted
//   i_repeat   frame count, 0 treated as 1
//   i_gap      idle cycles between frames, 0 = back-to-back
//   o_bit_seq  serial data, 0 when not shifting
//   o_bit_vld  high while o_bit_seq carries a frame bit
//   o_busy     high in every SHIFT/GAP cycle
//   o_done     1-cycle pulse after the last bit of the last frame
module bit_seq_transmitter #(
  parameter int DATA_W   = 8,
  parameter int REPEAT_W = 4,
  parameter int GAP_W    = 4
) (
  input  logic                i_clk,
  input  logic                i_rst,
  input  logic                i_start,
  input  logic [DATA_W-1:0]   i_data,
  input  logic [REPEAT_W-1:0] i_repeat,
  input  logic [GAP_W-1:0]    i_gap,
  output logic                o_bit_seq,
  output logic                o_bit_vld,
  output logic                o_busy,
  output logic                o_done
);

`ifdef PARITY_EN
  localparam int FRAME_W = DATA_W + 1;
`else
  localparam int FRAME_W = DATA_W;
`endif
  localparam int CNT_W = (FRAME_W > 1) ? $clog2(FRAME_W) : 1;
  localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(FRAME_W - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_SHIFT = 2'd1,
    S_GAP   = 2'd2
  } state_t;

  state_t                state_q, state_d;
  logic [FRAME_W-1:0]    pat_q, pat_d;
  logic [FRAME_W-1:0]    shift_q, shift_d;
  logic [CNT_W-1:0]      cnt_q, cnt_d;
  logic [REPEAT_W-1:0]   frames_q, frames_d;
  logic [GAP_W-1:0]      gap_q, gap_d;
  logic [GAP_W-1:0]      gap_cnt_q, gap_cnt_d;
  logic                  bit_seq_q, bit_seq_d;
  logic                  bit_vld_q, bit_vld_d;
  logic                  busy_q, busy_d;
  logic                  done_q, done_d;

  logic [FRAME_W-1:0]    in_frame;
  logic [FRAME_W-1:0]    frame_src;
  logic                  reload;

  always_comb begin
`ifdef PARITY_EN
    in_frame = {i_data, ^i_data};
`else
    in_frame = i_data;
`endif
  end

  always_comb begin
    state_d   = state_q;
    pat_d     = pat_q;
    shift_d   = shift_q;
    cnt_d     = cnt_q;
    frames_d  = frames_q;
    gap_d     = gap_q;
    gap_cnt_d = gap_cnt_q;
    bit_seq_d = 1'b0;
    bit_vld_d = 1'b0;
    done_d    = 1'b0;
    reload    = 1'b0;
    // A fresh start loads from the input pins; repeats reload the latched copy
    // so input changes mid-burst cannot leak into later frames.
    frame_src = (state_q == S_IDLE) ? in_frame : pat_q;

    case (state_q)
      S_IDLE: begin
        if (i_start) begin
          state_d  = S_SHIFT;
          pat_d    = in_frame;
          frames_d = (i_repeat == '0) ? REPEAT_W'(1) : i_repeat;
          gap_d    = i_gap;
          reload   = 1'b1;
        end
      end
      S_SHIFT: begin
        if (cnt_q != '0) begin
          bit_seq_d = shift_q[FRAME_W-1];
          bit_vld_d = 1'b1;
          shift_d   = shift_q << 1;
          cnt_d     = cnt_q - CNT_W'(1);
        end else if (frames_q > REPEAT_W'(1)) begin
          frames_d = frames_q - REPEAT_W'(1);
          if (gap_q != '0) begin
            state_d   = S_GAP;
            // The transition cycle itself is the first idle cycle.
            gap_cnt_d = gap_q - GAP_W'(1);
          end else begin
            reload = 1'b1;
          end
        end else begin
          state_d  = S_IDLE;
          frames_d = '0;
          done_d   = 1'b1;
        end
      end
      S_GAP: begin
        if (gap_cnt_q != '0) begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end else begin
          state_d = S_SHIFT;
          reload  = 1'b1;
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    // Present the MSB now and keep the rest in the shift register.
    if (reload) begin
      bit_seq_d = frame_src[FRAME_W-1];
      bit_vld_d = 1'b1;
      shift_d   = frame_src << 1;
      cnt_d     = CNT_LOAD;
    end

    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      pat_q     <= '0;
      shift_q   <= '0;
      cnt_q     <= '0;
      frames_q  <= '0;
      gap_q     <= '0;
      gap_cnt_q <= '0;
      bit_seq_q <= 1'b0;
      bit_vld_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      pat_q     <= pat_d;
      shift_q   <= shift_d;
      cnt_q     <= cnt_d;
      frames_q  <= frames_d;
      gap_q     <= gap_d;
      gap_cnt_q <= gap_cnt_d;
      bit_seq_q <= bit_seq_d;
      bit_vld_q <= bit_vld_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
    end
  end

  assign o_bit_seq = bit_seq_q;
  assign o_bit_vld = bit_vld_q;
  assign o_busy    = busy_q;
  assign o_done    = done_q;

endmodule

// File: tb/tb_bit_seq_transmitter.sv
// tb/tb_bit_seq_transmitter.sv - directed self-checking bench for bit_seq_transmitter
module tb_bit_seq_transmitter;
  localparam int DATA_W   = 8;
  localparam int REPEAT_W = 4;
  localparam int GAP_W    = 4;
`ifdef PARITY_EN
  localparam int FW = DATA_W + 1;
`else
  localparam int FW = DATA_W;
`endif

  logic                clk = 1'b0;
  logic                rst;
  logic                start;
  logic [DATA_W-1:0]   data;
  logic [REPEAT_W-1:0] rep;
  logic [GAP_W-1:0]    gap;
  logic                bit_seq, bit_vld, busy, done;

  int checks   = 0;
  int failures = 0;

  always #5 clk = ~clk;

  bit_seq_transmitter #(
    .DATA_W   (DATA_W),
    .REPEAT_W (REPEAT_W),
    .GAP_W    (GAP_W)
  ) dut (
    .i_clk     (clk),
    .i_rst     (rst),
    .i_start   (start),
    .i_data    (data),
    .i_repeat  (rep),
    .i_gap     (gap),
    .o_bit_seq (bit_seq),
    .o_bit_vld (bit_vld),
    .o_busy    (busy),
    .o_done    (done)
  );

  function automatic logic [FW-1:0] frame_of(input logic [DATA_W-1:0] d);
`ifdef PARITY_EN
    return {d, ^d};
`else
    return d;
`endif
  endfunction

  // Outputs are observed 1 time unit after the active edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Drive a start for one cycle; on return the first bit is visible.
  task automatic do_start(input logic [DATA_W-1:0] d, input logic [REPEAT_W-1:0] r,
                          input logic [GAP_W-1:0] g);
    data  = d;
    rep   = r;
    gap   = g;
    start = 1'b1;
    step();
    start = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1; start = 1'b0; data = '0; rep = '0; gap = '0;
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bit_seq, bit_vld, busy, done} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_outputs cyc=%0d got=%b exp=0000", i, {bit_seq, bit_vld, busy, done});
      end
    end
    rst = 1'b0;
    step();
    checks++;
    if ({bit_seq, bit_vld, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL post_reset_idle got=%b exp=0000", {bit_seq, bit_vld, busy, done});
    end
  endtask

  task automatic test_single();
    logic [FW-1:0] fr;
    fr = frame_of(8'hED);
    do_start(8'hED, 4'd1, 4'd0);
    for (int i = 0; i < FW; i++) begin
      checks++;
      if ({bit_seq, bit_vld, busy, done} !== {fr[FW-1-i], 3'b110}) begin
        failures++;
        $display("FAIL single_bit idx=%0d got=%b exp=%b", i, {bit_seq, bit_vld, busy, done}, {fr[FW-1-i], 3'b110});
      end
      step();
    end
    checks++;
    if ({bit_seq, bit_vld, busy, done} !== 4'b0001) begin
      failures++;
      $display("FAIL single_done got=%b exp=0001", {bit_seq, bit_vld, busy, done});
    end
    step();
    checks++;
    if ({bit_seq, bit_vld, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL single_done_pulse got=%b exp=0000", {bit_seq, bit_vld, busy, done});
    end
  endtask

  task automatic test_gap();
    logic [FW-1:0] fr;
    fr = frame_of(8'hA5);
    do_start(8'hA5, 4'd2, 4'd3);
    data = 8'h00; gap = 4'd0; rep = 4'd9;  // must not affect the burst in flight
    for (int f = 0; f < 2; f++) begin
      for (int i = 0; i < FW; i++) begin
        checks++;
        if ({bit_seq, bit_vld, busy, done} !== {fr[FW-1-i], 3'b110}) begin
          failures++;
          $display("FAIL gap_bit frame=%0d idx=%0d got=%b exp=%b", f, i, {bit_seq, bit_vld, busy, done}, {fr[FW-1-i], 3'b110});
        end
        step();
      end
      if (f == 0) begin
        for (int g = 0; g < 3; g++) begin
          checks++;
          if ({bit_seq, bit_vld, busy, done} !== 4'b0010) begin
            failures++;
            $display("FAIL gap_idle idx=%0d got=%b exp=0010", g, {bit_seq, bit_vld, busy, done});
          end
          step();
        end
      end
    end
    checks++;
    if ({bit_seq, bit_vld, busy, done} !== 4'b0001) begin
      failures++;
      $display("FAIL gap_done got=%b exp=0001", {bit_seq, bit_vld, busy, done});
    end
    step();
  endtask

  task automatic test_back_to_back();
    logic [FW-1:0] fr;
    fr = frame_of(8'h3C);
    do_start(8'h3C, 4'd2, 4'd0);
    for (int i = 0; i < 2 * FW; i++) begin
      checks++;
      if ({bit_seq, bit_vld, busy, done} !== {fr[FW-1-(i%FW)], 3'b110}) begin
        failures++;
        $display("FAIL b2b_bit idx=%0d got=%b exp=%b", i, {bit_seq, bit_vld, busy, done}, {fr[FW-1-(i%FW)], 3'b110});
      end
      step();
    end
    checks++;
    if ({bit_seq, bit_vld, busy, done} !== 4'b0001) begin
      failures++;
      $display("FAIL b2b_done got=%b exp=0001", {bit_seq, bit_vld, busy, done});
    end
    step();
  endtask

  task automatic test_ignore_start();
    logic [FW-1:0] fr;
    fr = frame_of(8'h0F);
    do_start(8'h0F, 4'd0, 4'd0);
    for (int i = 0; i < FW; i++) begin
      checks++;
      if ({bit_seq, bit_vld, busy, done} !== {fr[FW-1-i], 3'b110}) begin
        failures++;
        $display("FAIL ignore_bit idx=%0d got=%b exp=%b", i, {bit_seq, bit_vld, busy, done}, {fr[FW-1-i], 3'b110});
      end
      if (i == 4) begin
        start = 1'b1; data = 8'hFF;
      end else begin
        start = 1'b0;
      end
      step();
    end
    start = 1'b0;
    checks++;
    if ({bit_seq, bit_vld, busy, done} !== 4'b0001) begin
      failures++;
      $display("FAIL ignore_done got=%b exp=0001", {bit_seq, bit_vld, busy, done});
    end
    for (int i = 0; i < 3; i++) begin
      step();
      checks++;
      if ({bit_seq, bit_vld, busy, done} !== 4'b0000) begin
        failures++;
        $display("FAIL ignore_no_second idx=%0d got=%b exp=0000", i, {bit_seq, bit_vld, busy, done});
      end
    end
  endtask

  task automatic test_reset_mid();
    logic [FW-1:0] fr;
    fr = frame_of(8'hED);
    do_start(8'hED, 4'd3, 4'd0);
    for (int i = 0; i < 4; i++) step();
    rst = 1'b1; start = 1'b1;  // reset wins over a simultaneous start
    step();
    rst = 1'b0; start = 1'b0;
    checks++;
    if ({bit_seq, bit_vld, busy, done} !== 4'b0000) begin
      failures++;
      $display("FAIL reset_mid_edge got=%b exp=0000", {bit_seq, bit_vld, busy, done});
    end
    for (int i = 0; i < 12; i++) begin
      step();
      checks++;
      if ({bit_seq, bit_vld, busy, done} !== 4'b0000) begin
        failures++;
        $display("FAIL reset_mid_quiet idx=%0d got=%b exp=0000", i, {bit_seq, bit_vld, busy, done});
      end
    end
    do_start(8'hED, 4'd1, 4'd0);
    for (int i = 0; i < FW; i++) begin
      checks++;
      if ({bit_seq, bit_vld, busy, done} !== {fr[FW-1-i], 3'b110}) begin
        failures++;
        $display("FAIL reset_fresh_bit idx=%0d got=%b exp=%b", i, {bit_seq, bit_vld, busy, done}, {fr[FW-1-i], 3'b110});
      end
      step();
    end
    checks++;
    if ({bit_seq, bit_vld, busy, done} !== 4'b0001) begin
      failures++;
      $display("FAIL reset_fresh_done got=%b exp=0001", {bit_seq, bit_vld, busy, done});
    end
    step();
  endtask

  task automatic test_done_restart();
    logic [FW-1:0] fr;
    fr = frame_of(8'h7E);
    do_start(8'h81, 4'd1, 4'd0);
    for (int i = 0; i < FW; i++) step();
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL restart_done got=%b exp=1", done);
    end
    do_start(8'h7E, 4'd1, 4'd0);
    for (int i = 0; i < FW; i++) begin
      checks++;
      if ({bit_seq, bit_vld, busy, done} !== {fr[FW-1-i], 3'b110}) begin
        failures++;
        $display("FAIL restart_bit idx=%0d got=%b exp=%b", i, {bit_seq, bit_vld, busy, done}, {fr[FW-1-i], 3'b110});
      end
      step();
    end
    checks++;
    if ({bit_seq, bit_vld, busy, done} !== 4'b0001) begin
      failures++;
      $display("FAIL restart_done2 got=%b exp=0001", {bit_seq, bit_vld, busy, done});
    end
    step();
  endtask

  task automatic test_max_repeat();
    int cyc;
    int vcnt;
    int bcnt;
    cyc = 0; vcnt = 0; bcnt = 0;
    do_start(8'hC3, 4'hF, 4'd1);
    while (done !== 1'b1 && cyc < 400) begin
      if (bit_vld === 1'b1) vcnt++;
      if (busy === 1'b1) bcnt++;
      cyc++;
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL max_repeat_timeout cycles=%0d", cyc);
    end
    checks++;
    if (vcnt != 15 * FW) begin
      failures++;
      $display("FAIL max_repeat_bits got=%0d exp=%0d", vcnt, 15 * FW);
    end
    checks++;
    if (bcnt != 15 * FW + 14) begin
      failures++;
      $display("FAIL max_repeat_busy got=%0d exp=%0d", bcnt, 15 * FW + 14);
    end
    step();
  endtask

`ifdef PARITY_EN
  task automatic test_parity();
    logic [8:0] exp_ed;
    logic [8:0] exp_01;
    exp_ed = 9'b1110_1101_0;
    exp_01 = 9'b0000_0001_1;
    do_start(8'hED, 4'd1, 4'd0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if ({bit_seq, bit_vld} !== {exp_ed[8-i], 1'b1}) begin
        failures++;
        $display("FAIL parity_ed idx=%0d got=%b exp=%b", i, {bit_seq, bit_vld}, {exp_ed[8-i], 1'b1});
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL parity_ed_done got=%b exp=1", done);
    end
    step();
    do_start(8'h01, 4'd1, 4'd0);
    for (int i = 0; i < 9; i++) begin
      checks++;
      if ({bit_seq, bit_vld} !== {exp_01[8-i], 1'b1}) begin
        failures++;
        $display("FAIL parity_01 idx=%0d got=%b exp=%b", i, {bit_seq, bit_vld}, {exp_01[8-i], 1'b1});
      end
      step();
    end
    checks++;
    if (done !== 1'b1) begin
      failures++;
      $display("FAIL parity_01_done got=%b exp=1", done);
    end
    step();
  endtask
`endif

  initial begin
    test_reset();
    test_single();
    test_gap();
    test_back_to_back();
    test_ignore_start();
    test_reset_mid();
    test_done_restart();
    test_max_repeat();
`ifdef PARITY_EN
    test_parity();
`endif
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
